// File: rtl/mem_responder.sv
// Memory-side responder for the MAR/MDR interface: captures a read/write request,
// inserts programmable wait states, then completes with a one-cycle Mem_done pulse.
module mem_responder #(
  parameter int ADDR_W      = 9,
  parameter int DEPTH       = 512,
  parameter int WAIT_STATES = 2
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [ADDR_W-1:0] MAR_addr,
  input  logic [31:0]       MDR_data,
  input  logic              Read,
  input  logic              Write,
  output logic [31:0]       mdata_out,
  output logic              Mem_busy,
  output logic              Mem_done,
  output logic              Mem_err
);

  localparam int DATA_W = 32;
  localparam int IDX_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [3:0]      WS_LOAD   = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;
  localparam logic [ADDR_W:0] DEPTH_EXT = (ADDR_W + 1)'(DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_t;

  state_t state, state_nxt;
  logic [3:0] cnt, cnt_nxt;

  logic              vld_p0;
  logic [ADDR_W-1:0] addr_p0;
  logic [DATA_W-1:0] data_p0;
  logic              op_rd_p0;
  logic              op_wr_p0;

  logic [DATA_W-1:0] mem [DEPTH];

  logic              accept;
  logic              in_range;
  logic              conflict;
  logic              load_rd;
  logic [IDX_W-1:0]  idx;
  logic [DATA_W-1:0] rd_word;

  // A request is only sampled in IDLE once the previous capture has been consumed.
  assign accept   = (state == S_IDLE) && !vld_p0 && (Read || Write);
  assign in_range = ({1'b0, addr_p0} < DEPTH_EXT);
  assign conflict = op_rd_p0 && op_wr_p0;
  assign idx      = addr_p0[IDX_W-1:0];
  assign rd_word  = in_range ? mem[idx] : '0;
  assign load_rd  = (state_nxt == S_DONE) && (state != S_DONE) && op_rd_p0 && !op_wr_p0;

  // Stage p0: request capture, held stable for the whole operation
  always_ff @(posedge clock) begin
    if (accept) begin
      addr_p0  <= MAR_addr;
      data_p0  <= MDR_data;
      op_rd_p0 <= Read;
      op_wr_p0 <= Write;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state     <= S_IDLE;
      cnt       <= '0;
      vld_p0    <= 1'b0;
      mdata_out <= '0;
    end else begin
      state  <= state_nxt;
      cnt    <= cnt_nxt;
      vld_p0 <= accept;
      if (load_rd) mdata_out <= rd_word;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      S_IDLE: begin
        if (vld_p0) begin
          if (WAIT_STATES > 0) begin
            state_nxt = S_WAIT;
            cnt_nxt   = WS_LOAD;
          end else begin
            state_nxt = S_DONE;
          end
        end
      end
      S_WAIT: begin
        if (cnt == 4'd0) state_nxt = S_DONE;
        else             cnt_nxt   = cnt - 4'd1;
      end
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Stage done: RAM commit on the edge leaving DONE; an async reset aborts it
  always_ff @(posedge clock) begin
    if ((state == S_DONE) && op_wr_p0 && !op_rd_p0 && in_range)
      mem[idx] <= data_p0;
  end

  assign Mem_busy = vld_p0 || (state != S_IDLE);
  assign Mem_done = (state == S_DONE);
  assign Mem_err  = (state == S_DONE) && (conflict || !in_range);

endmodule

// File: tb/tb_mem_responder.sv
// Bench for mem_responder: two instances (2 wait states / 512 words and
// 0 wait states / 256 words) share the request inputs; a scoreboard checks each.
module tb_mem_responder;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [8:0]  MAR_addr = '0;
  logic [31:0] MDR_data = '0;
  logic        Read = 1'b0;
  logic        Write = 1'b0;

  logic [31:0] mdata_a, mdata_b;
  logic        busy_a, busy_b, done_a, done_b, err_a, err_b;

  mem_responder #(.ADDR_W(9), .DEPTH(512), .WAIT_STATES(2)) u_a (
    .clock(clock), .reset(reset), .MAR_addr(MAR_addr), .MDR_data(MDR_data),
    .Read(Read), .Write(Write), .mdata_out(mdata_a), .Mem_busy(busy_a),
    .Mem_done(done_a), .Mem_err(err_a)
  );

  mem_responder #(.ADDR_W(9), .DEPTH(256), .WAIT_STATES(0)) u_b (
    .clock(clock), .reset(reset), .MAR_addr(MAR_addr), .MDR_data(MDR_data),
    .Read(Read), .Write(Write), .mdata_out(mdata_b), .Mem_busy(busy_b),
    .Mem_done(done_b), .Mem_err(err_b)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] data;
    logic        err;
    int          due;
  } exp_t;

  typedef struct {
    logic        rd;
    logic        wr;
    logic [8:0]  addr;
    logic [31:0] data;
    logic [31:0] ea_d;
    logic        ea_e;
    logic [31:0] eb_d;
    logic        eb_e;
  } vec_t;

  exp_t q_a[$];
  exp_t q_b[$];
  vec_t vt[15];

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Advance to the next falling edge and retire any completions seen there.
  task automatic tick();
    exp_t e;
    @(negedge clock);
    if (done_a) begin
      if (q_a.size() == 0) check("done_a_unexpected", done_a, 0);
      else begin
        e = q_a.pop_front();
        check("due_a", cyc, e.due);
        check("data_a", mdata_a, e.data);
        check("err_a", err_a, e.err);
        check("busy_at_done_a", busy_a, 1);
      end
    end else if (q_a.size() > 0 && q_a[0].due <= cyc) begin
      check("done_a_missing", done_a, 1);
      void'(q_a.pop_front());
    end
    if (done_b) begin
      if (q_b.size() == 0) check("done_b_unexpected", done_b, 0);
      else begin
        e = q_b.pop_front();
        check("due_b", cyc, e.due);
        check("data_b", mdata_b, e.data);
        check("err_b", err_b, e.err);
        check("busy_at_done_b", busy_b, 1);
      end
    end else if (q_b.size() > 0 && q_b[0].due <= cyc) begin
      check("done_b_missing", done_b, 1);
      void'(q_b.pop_front());
    end
    if (err_a && !done_a) check("err_a_without_done", err_a, 0);
    if (err_b && !done_b) check("err_b_without_done", err_b, 0);
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 30 && (q_a.size() > 0 || q_b.size() > 0); i++) tick();
    if (q_a.size() > 0 || q_b.size() > 0) begin
      check("drain_timeout", q_a.size() + q_b.size(), 0);
      q_a.delete();
      q_b.delete();
    end
    tick();
    tick();
  endtask

  // Called at a falling edge; the request is sampled on the next rising edge,
  // after which the inputs are scrambled to prove only latched values are used.
  task automatic do_req(input vec_t v);
    Read     = v.rd;
    Write    = v.wr;
    MAR_addr = v.addr;
    MDR_data = v.data;
    q_a.push_back('{v.ea_d, v.ea_e, cyc + 4});
    q_b.push_back('{v.eb_d, v.eb_e, cyc + 2});
    tick();
    Read     = 1'b0;
    Write    = 1'b0;
    MAR_addr = 9'h010;
    MDR_data = ~v.data;
    check("busy_start_a", busy_a, 1);
    check("busy_start_b", busy_b, 1);
    wait_drain();
  endtask

  task automatic check_quiet(input string tag);
    check({tag, "_mdata_a"}, mdata_a, 32'h0);
    check({tag, "_mdata_b"}, mdata_b, 32'h0);
    check({tag, "_busy_a"}, busy_a, 0);
    check({tag, "_busy_b"}, busy_b, 0);
    check({tag, "_done_a"}, done_a, 0);
    check({tag, "_done_b"}, done_b, 0);
  endtask

  initial begin
    int k;
    vec_t rd030;

    //          rd    wr    addr    data          exp data a    ea    exp data b    eb
    vt[0]  = '{1'b0, 1'b1, 9'h010, 32'hDEADBEEF, 32'h00000000, 1'b0, 32'h00000000, 1'b0};
    vt[1]  = '{1'b1, 1'b0, 9'h010, 32'h00000000, 32'hDEADBEEF, 1'b0, 32'hDEADBEEF, 1'b0};
    vt[2]  = '{1'b0, 1'b1, 9'h001, 32'h12345678, 32'hDEADBEEF, 1'b0, 32'hDEADBEEF, 1'b0};
    vt[3]  = '{1'b1, 1'b0, 9'h001, 32'h00000000, 32'h12345678, 1'b0, 32'h12345678, 1'b0};
    vt[4]  = '{1'b0, 1'b1, 9'h1FF, 32'hCAFEF00D, 32'h12345678, 1'b0, 32'h12345678, 1'b1};
    vt[5]  = '{1'b1, 1'b0, 9'h1FF, 32'h00000000, 32'hCAFEF00D, 1'b0, 32'h00000000, 1'b1};
    vt[6]  = '{1'b1, 1'b1, 9'h010, 32'h11111111, 32'hCAFEF00D, 1'b1, 32'h00000000, 1'b1};
    vt[7]  = '{1'b1, 1'b0, 9'h010, 32'h00000000, 32'hDEADBEEF, 1'b0, 32'hDEADBEEF, 1'b0};
    vt[8]  = '{1'b0, 1'b1, 9'h020, 32'hA5A5A5A5, 32'hDEADBEEF, 1'b0, 32'hDEADBEEF, 1'b0};
    vt[9]  = '{1'b1, 1'b0, 9'h020, 32'h00000000, 32'hA5A5A5A5, 1'b0, 32'hA5A5A5A5, 1'b0};
    vt[10] = '{1'b0, 1'b1, 9'h030, 32'h13572468, 32'hA5A5A5A5, 1'b0, 32'hA5A5A5A5, 1'b0};
    vt[11] = '{1'b1, 1'b0, 9'h030, 32'h00000000, 32'h13572468, 1'b0, 32'h13572468, 1'b0};
    vt[12] = '{1'b1, 1'b0, 9'h010, 32'h00000000, 32'hDEADBEEF, 1'b0, 32'hDEADBEEF, 1'b0};
    vt[13] = '{1'b0, 1'b1, 9'h0FF, 32'h0F0F0F0F, 32'hDEADBEEF, 1'b0, 32'hDEADBEEF, 1'b0};
    vt[14] = '{1'b1, 1'b0, 9'h0FF, 32'h00000000, 32'h0F0F0F0F, 1'b0, 32'h0F0F0F0F, 1'b0};

    // Reset held for two cycles, then five idle cycles
    tick();
    check_quiet("in_reset0");
    tick();
    check_quiet("in_reset1");
    reset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      check_quiet("idle");
    end

    for (int i = 0; i < 15; i++) do_req(vt[i]);

    // Read held high: each instance re-accepts after one idle cycle
    k = cyc;
    Read     = 1'b1;
    Write    = 1'b0;
    MAR_addr = 9'h010;
    q_a.push_back('{32'hDEADBEEF, 1'b0, k + 4});
    q_a.push_back('{32'hDEADBEEF, 1'b0, k + 9});
    q_b.push_back('{32'hDEADBEEF, 1'b0, k + 2});
    q_b.push_back('{32'hDEADBEEF, 1'b0, k + 5});
    repeat (6) tick();
    Read = 1'b0;
    wait_drain();

    // Reset while the write of 32'h0BADF00D to 9'h030 is waiting
    Write    = 1'b1;
    MAR_addr = 9'h030;
    MDR_data = 32'h0BADF00D;
    @(posedge clock);
    #1;
    Write    = 1'b0;
    MAR_addr = 9'h000;
    @(posedge clock);
    #1;
    reset = 1'b1;
    tick();
    check_quiet("mid_reset0");
    tick();
    check_quiet("mid_reset1");
    reset = 1'b0;
    repeat (6) tick();
    check_quiet("after_abort");

    rd030 = '{1'b1, 1'b0, 9'h030, 32'h00000000, 32'h13572468, 1'b0, 32'h13572468, 1'b0};
    do_req(rd030);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, tests run %0d", n_tests);
    $fatal(1, "watchdog expired");
  end

endmodule
